// File: rtl/clock_gate_ctrl_pkg.sv
// Shared types and defaults for the core clock-gate sequencing controller.
// Optional idle-cycle counter is enabled with CLOCK_GATE_IDLE_CNT_EN.
package clock_gate_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_GATED = 2'd2,
      ST_WAKE  = 2'd3
   } cg_state_t;

   localparam int unsigned QUIET_CYCLES_DEF  = 4;
   localparam int unsigned DRAIN_TIMEOUT_DEF = 1024;
   localparam int unsigned WAKE_SETTLE_DEF   = 2;
   localparam int unsigned IDLE_CNT_W        = 32;

endpackage

// File: rtl/clock_gate_ctrl.sv
// Core clock-gate sequencer: drains to quiet, pauses the gate, resumes on wake.
// Define CLOCK_GATE_IDLE_CNT_EN to build the saturating gated-cycle counter.
module clock_gate_ctrl
   import clock_gate_ctrl_pkg::*;
#(
   parameter int unsigned QUIET_CYCLES  = QUIET_CYCLES_DEF,
   parameter int unsigned DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
   parameter int unsigned WAKE_SETTLE   = WAKE_SETTLE_DEF
) (
   input  logic                  aclk,
   input  logic                  reset,
   input  logic                  idle_req,
   input  logic                  pipe_empty,
   input  logic                  bus_idle,
   input  logic                  wake,
   output logic                  clear_clock_gate,
   output logic                  set_clock_gate,
   output logic                  gated,
   output logic                  idle_done,
   output logic                  idle_abort,
   output logic [1:0]            state,
   output logic [IDLE_CNT_W-1:0] idle_cycles
);

   localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
   localparam int unsigned TW = $clog2(DRAIN_TIMEOUT + 1);
   localparam int unsigned SW = $clog2(WAKE_SETTLE + 1);

   localparam logic [QW-1:0] QUIET_LAST  = QW'(QUIET_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST    = TW'(DRAIN_TIMEOUT - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(WAKE_SETTLE - 1);

   cg_state_t      state_q;
   cg_state_t      state_d;
   logic [QW-1:0]  quiet_cnt;
   logic [TW-1:0]  tmo_cnt;
   logic [SW-1:0]  settle_cnt;
   logic           quiet;

   logic           clear_d;
   logic           set_d;
   logic           gated_d;
   logic           done_d;
   logic           abort_d;

   assign quiet = pipe_empty & bus_idle;

   always_ff @(posedge aclk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // In DRAIN: wake beats timeout, timeout beats a completed quiet window.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (idle_req && !wake) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (wake || (tmo_cnt == TMO_LAST)) begin
               state_d = ST_RUN;
            end else if (quiet && (quiet_cnt == QUIET_LAST)) begin
               state_d = ST_GATED;
            end
         end
         ST_GATED: begin
            if (wake) begin
               state_d = ST_WAKE;
            end
         end
         ST_WAKE: begin
            if (settle_cnt == SETTLE_LAST) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      clear_d = (state_d == ST_GATED);
      gated_d = (state_d == ST_GATED);
      set_d   = (state_q == ST_GATED) && (state_d == ST_WAKE);
      done_d  = (state_q == ST_WAKE) && (state_d == ST_RUN);
      abort_d = ((state_q == ST_RUN) && idle_req && wake) ||
                ((state_q == ST_DRAIN) && (state_d == ST_RUN));
   end

   // Outputs are registered alongside the state so the gate sees clean levels.
   always_ff @(posedge aclk) begin
      if (reset) begin
         clear_clock_gate <= 1'b0;
         set_clock_gate   <= 1'b0;
         gated            <= 1'b0;
         idle_done        <= 1'b0;
         idle_abort       <= 1'b0;
      end else begin
         clear_clock_gate <= clear_d;
         set_clock_gate   <= set_d;
         gated            <= gated_d;
         idle_done        <= done_d;
         idle_abort       <= abort_d;
      end
   end

   // Counters are held at zero outside their state, so each entry starts fresh.
   always_ff @(posedge aclk) begin
      if (reset) begin
         quiet_cnt  <= '0;
         tmo_cnt    <= '0;
         settle_cnt <= '0;
      end else begin
         if (state_q == ST_DRAIN) begin
            quiet_cnt <= quiet ? (quiet_cnt + QW'(1)) : '0;
            tmo_cnt   <= tmo_cnt + TW'(1);
         end else begin
            quiet_cnt <= '0;
            tmo_cnt   <= '0;
         end
         settle_cnt <= (state_q == ST_WAKE) ? (settle_cnt + SW'(1)) : '0;
      end
   end

   assign state = state_q;

`ifdef CLOCK_GATE_IDLE_CNT_EN
   logic [IDLE_CNT_W-1:0] idle_cnt_q;

   always_ff @(posedge aclk) begin
      if (reset) begin
         idle_cnt_q <= '0;
      end else if (gated && (idle_cnt_q != '1)) begin
         idle_cnt_q <= idle_cnt_q + IDLE_CNT_W'(1);
      end
   end

   assign idle_cycles = idle_cnt_q;
`else
   assign idle_cycles = '0;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Self-checking bench for clock_gate_ctrl: directed scenarios plus randomized
// drain patterns scored against an arithmetic model of the idle sequence.
module tb_clock_gate_ctrl;

   localparam int unsigned QC = 4;
   localparam int unsigned DT = 16;
   localparam int unsigned WS = 2;
`ifdef CLOCK_GATE_IDLE_CNT_EN
   localparam bit IDLE_CNT_EN = 1'b1;
`else
   localparam bit IDLE_CNT_EN = 1'b0;
`endif

   localparam logic [1:0] EV_ABORT = 2'b01;
   localparam logic [1:0] EV_DONE  = 2'b10;

   logic        aclk;
   logic        reset;
   logic        idle_req;
   logic        pipe_empty;
   logic        bus_idle;
   logic        wake;
   logic        clear_clock_gate;
   logic        set_clock_gate;
   logic        gated;
   logic        idle_done;
   logic        idle_abort;
   logic [1:0]  state;
   logic [31:0] idle_cycles;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          mon_en   = 1'b0;
   longint      exp_idle = 0;
   logic [1:0]  exp_q[$];

   clock_gate_ctrl #(
      .QUIET_CYCLES (QC),
      .DRAIN_TIMEOUT(DT),
      .WAKE_SETTLE  (WS)
   ) dut (
      .aclk            (aclk),
      .reset           (reset),
      .idle_req        (idle_req),
      .pipe_empty      (pipe_empty),
      .bus_idle        (bus_idle),
      .wake            (wake),
      .clear_clock_gate(clear_clock_gate),
      .set_clock_gate  (set_clock_gate),
      .gated           (gated),
      .idle_done       (idle_done),
      .idle_abort      (idle_abort),
      .state           (state),
      .idle_cycles     (idle_cycles)
   );

   // ---------------- clock / reset ----------------
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive_quiet(input logic q);
      int sel;
      if (q) begin
         pipe_empty = 1'b1;
         bus_idle   = 1'b1;
      end else begin
         sel = $urandom_range(0, 2);
         pipe_empty = (sel == 1);
         bus_idle   = (sel == 0);
      end
   endtask

   function automatic logic [31:0] exp_ic();
      return IDLE_CNT_EN ? 32'(exp_idle) : 32'd0;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(posedge aclk) begin
      logic [1:0] obs;
      logic [1:0] exp;
      #1;
      if (mon_en) begin
         n_checks++;
         if (set_clock_gate && (clear_clock_gate || state != 2'd3)) begin
            n_fail++;
            $display("FAIL set_invariant: set=%0b clear=%0b state=%0d, required set only alone in WAKE",
                     set_clock_gate, clear_clock_gate, state);
         end
         if (idle_abort || idle_done) begin
            n_checks++;
            obs = {idle_done, idle_abort};
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL pulse_scoreboard: got event %b, expected no event", obs);
            end else begin
               exp = exp_q.pop_front();
               if (obs !== exp) begin
                  n_fail++;
                  $display("FAIL pulse_scoreboard: got event %b, expected %b", obs, exp);
               end
            end
         end
      end
   end

   // One full idle attempt. q[k]/w[k] are the quiet and wake samples at the
   // k-th edge after the idle_req edge; hold is extra gated cycles before wake.
   task automatic run_idle(input string name, input logic [31:0] q, input logic [31:0] w,
                           input int hold);
      int  k_end;
      int  run;
      bit  gate;
      k_end = 0;
      run   = 0;
      gate  = 1'b0;
      for (int k = 1; k <= int'(DT) && k_end == 0; k++) begin
         run = q[k] ? run + 1 : 0;
         if (w[k]) k_end = k;
         else if (k == int'(DT)) k_end = k;
         else if (run >= int'(QC)) begin
            k_end = k;
            gate  = 1'b1;
         end
      end
      exp_q.push_back(gate ? EV_DONE : EV_ABORT);

      idle_req = 1'b1;
      wake     = 1'b0;
      drive_quiet(1'b1);
      tick();
      idle_req = 1'b0;
      for (int k = 1; k <= k_end; k++) begin
         drive_quiet(q[k]);
         wake = w[k];
         n_checks++;
         if ({state, clear_clock_gate, idle_abort, gated} !== {2'd1, 3'b000}) begin
            n_fail++;
            $display("FAIL %s.drain_k%0d: got st=%0d clr=%0b abt=%0b gtd=%0b, expected st=1 clr=0 abt=0 gtd=0",
                     name, k, state, clear_clock_gate, idle_abort, gated);
         end
         tick();
      end

      if (!gate) begin
         n_checks++;
         if ({state, idle_abort, clear_clock_gate} !== {2'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL %s.abort_edge%0d: got st=%0d abt=%0b clr=%0b, expected st=0 abt=1 clr=0",
                     name, k_end, state, idle_abort, clear_clock_gate);
         end
         wake = 1'b0;
         tick();
         n_checks++;
         if ({state, idle_abort} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s.abort_after: got st=%0d abt=%0b, expected st=0 abt=0",
                     name, state, idle_abort);
         end
         return;
      end

      wake = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         n_checks++;
         if ({state, clear_clock_gate, set_clock_gate, gated} !== {2'd2, 3'b101}) begin
            n_fail++;
            $display("FAIL %s.gated_h%0d: got st=%0d clr=%0b set=%0b gtd=%0b, expected st=2 clr=1 set=0 gtd=1",
                     name, h, state, clear_clock_gate, set_clock_gate, gated);
         end
         if (h == hold) wake = 1'b1;
         drive_quiet($urandom_range(0, 1) == 1);
         tick();
      end
      exp_idle += hold + 1;

      n_checks++;
      if ({state, clear_clock_gate, set_clock_gate, gated} !== {2'd3, 3'b010}) begin
         n_fail++;
         $display("FAIL %s.wake_entry: got st=%0d clr=%0b set=%0b gtd=%0b, expected st=3 clr=0 set=1 gtd=0",
                  name, state, clear_clock_gate, set_clock_gate, gated);
      end
      n_checks++;
      if (idle_cycles !== exp_ic()) begin
         n_fail++;
         $display("FAIL %s.idle_cycles: got %0d, expected %0d", name, idle_cycles, exp_ic());
      end
      for (int s = 1; s < int'(WS); s++) begin
         wake = ($urandom_range(0, 1) == 1);
         tick();
         n_checks++;
         if ({state, set_clock_gate, idle_done} !== {2'd3, 2'b00}) begin
            n_fail++;
            $display("FAIL %s.settle_%0d: got st=%0d set=%0b done=%0b, expected st=3 set=0 done=0",
                     name, s, state, set_clock_gate, idle_done);
         end
      end
      wake = ($urandom_range(0, 1) == 1);
      tick();
      n_checks++;
      if ({state, idle_done, clear_clock_gate} !== {2'd0, 2'b10}) begin
         n_fail++;
         $display("FAIL %s.done_edge: got st=%0d done=%0b clr=%0b, expected st=0 done=1 clr=0",
                  name, state, idle_done, clear_clock_gate);
      end
      wake = 1'b0;
      tick();
      n_checks++;
      if ({state, idle_done, set_clock_gate} !== {2'd0, 2'b00}) begin
         n_fail++;
         $display("FAIL %s.after_done: got st=%0d done=%0b set=%0b, expected st=0 done=0 set=0",
                  name, state, idle_done, set_clock_gate);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset      = 1'b1;
      idle_req   = 1'b0;
      pipe_empty = 1'b0;
      bus_idle   = 1'b0;
      wake       = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({state, clear_clock_gate, set_clock_gate, gated, idle_done, idle_abort} !== 7'd0 ||
          idle_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: got st=%0d clr=%0b set=%0b gtd=%0b done=%0b abt=%0b ic=%0d, expected all 0",
                  state, clear_clock_gate, set_clock_gate, gated, idle_done, idle_abort, idle_cycles);
      end
      reset    = 1'b0;
      exp_idle = 0;
      mon_en   = 1'b1;
      tick();
   endtask

   task automatic test_normal();
      run_idle("normal", 32'hFFFF_FFFE, 32'd0, 2);
   endtask

   task automatic test_quiet_interrupt();
      // quiet at edges 1..3, broken at 4, fresh quiet from 5 onward
      run_idle("quiet_interrupt", 32'hFFFF_FFEE, 32'd0, 1);
   endtask

   task automatic test_abort_paths();
      run_idle("wake_in_drain", 32'hFFFF_FFFE, 32'h0000_0004, 0);
      run_idle("drain_timeout", 32'd0, 32'd0, 0);
   endtask

   task automatic test_req_with_wake();
      exp_q.push_back(EV_ABORT);
      idle_req = 1'b1;
      wake     = 1'b1;
      drive_quiet(1'b1);
      tick();
      idle_req = 1'b0;
      n_checks++;
      if ({state, idle_abort} !== {2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL req_with_wake: got st=%0d abt=%0b, expected st=0 abt=1", state, idle_abort);
      end
      wake = 1'b0;
      tick();
      n_checks++;
      if ({state, idle_abort} !== {2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL req_with_wake.after: got st=%0d abt=%0b, expected st=0 abt=0", state, idle_abort);
      end
   endtask

   task automatic test_wake_at_gate_entry();
      run_idle("wake_at_gate_entry", 32'hFFFF_FFFE, 32'd0, 0);
   endtask

   task automatic test_reset_in_gated();
      idle_req = 1'b1;
      wake     = 1'b0;
      drive_quiet(1'b1);
      tick();
      idle_req = 1'b0;
      for (int k = 0; k < int'(QC); k++) tick();
      n_checks++;
      if ({state, gated} !== {2'd2, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_in_gated.entry: got st=%0d gtd=%0b, expected st=2 gtd=1", state, gated);
      end
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      exp_idle = 0;
      n_checks++;
      if ({state, clear_clock_gate, set_clock_gate, gated} !== 5'd0 || idle_cycles !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_in_gated: got st=%0d clr=%0b set=%0b gtd=%0b ic=%0d, expected all 0",
                  state, clear_clock_gate, set_clock_gate, gated, idle_cycles);
      end
      tick();
      n_checks++;
      if ({state, set_clock_gate} !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_in_gated.after: got st=%0d set=%0b, expected st=0 set=0",
                  state, set_clock_gate);
      end
   endtask

   task automatic test_idle_count();
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      exp_idle = 0;
      run_idle("idle_count", 32'hFFFF_FFFE, 32'd0, 99);
      n_checks++;
      if (idle_cycles !== (IDLE_CNT_EN ? 32'd100 : 32'd0)) begin
         n_fail++;
         $display("FAIL idle_count.total: got %0d, expected %0d",
                  idle_cycles, IDLE_CNT_EN ? 100 : 0);
      end
   endtask

   task automatic test_random();
      logic [31:0] q;
      logic [31:0] w;
      for (int it = 0; it < 30; it++) begin
         q = '0;
         w = '0;
         for (int k = 1; k <= int'(DT); k++) begin
            q[k] = ($urandom_range(0, 5) != 0);
            w[k] = ($urandom_range(0, 24) == 0);
         end
         run_idle($sformatf("random_%0d", it), q, w, $urandom_range(0, 5));
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_normal();
      test_quiet_interrupt();
      test_abort_paths();
      test_req_with_wake();
      test_wake_at_gate_entry();
      test_reset_in_gated();
      test_idle_count();
      test_random();
      tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL pulse_scoreboard.drain: got %0d outstanding events, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
